// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register map and fixed bit positions shared by the interrupt controller files
package irq_ctrl_pkg;
   typedef enum logic [2:0] {
      REG_ENABLE  = 3'd0,
      REG_MODE    = 3'd1,
      REG_PENDING = 3'd2,
      REG_SET     = 3'd3,
      REG_TOP     = 3'd4
   } reg_sel_e;
   localparam int IRQ_FAST_BASE = 16;
   localparam int TOP_VALID_BIT = 31;
endpackage

// File: rtl/irq_ctrl_src.sv
// irq_ctrl_src: edge detector and pending latch with set-over-clear priority for one source
module irq_ctrl_src (
   input  logic clk,
   input  logic rst,
   input  logic i_src,
   input  logic i_mode,
   input  logic i_set,
   input  logic i_clr,
   output logic o_pending
);
   logic r_prev, r_pending, w_rise, w_next;
   assign w_rise = i_src & ~r_prev;
   // level mode tracks the line, so a software set only lasts one cycle there
   assign w_next = i_mode ? (i_set | w_rise | (r_pending & ~i_clr)) : (i_src | i_set);
   assign o_pending = r_pending;
   always_ff @(posedge clk) begin
      r_prev    <= i_src;
      r_pending <= rst ? 1'b0 : w_next;
   end
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: bus-programmable interrupt controller mapping NUM_SRC sources onto core fast irqs 16+i
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int NUM_SRC = 8,
   parameter int ADDR_W  = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] src_i,
   input  logic               req_i,
   input  logic               we_i,
   input  logic [3:0]         be_i,
   input  logic [ADDR_W-1:0]  addr_i,
   input  logic [31:0]        wdata_i,
   output logic               gnt_o,
   output logic               rvalid_o,
   output logic [31:0]        rdata_o,
   output logic [31:0]        irq_o,
   input  logic               irq_ack_i,
   input  logic [4:0]         irq_id_i
);
   logic [NUM_SRC-1:0] r_enable, r_mode, r_irq;
   logic [NUM_SRC-1:0] w_pending, w_wbits, w_bmask_src, w_set, w_clr;
   logic [31:0]        w_bmask, w_top, w_rdata, r_rdata;
   logic               r_rvalid, w_wr, w_unused;
   reg_sel_e           w_sel;

   assign gnt_o       = req_i;
   assign rvalid_o    = r_rvalid;
   assign rdata_o     = r_rdata;
   assign w_sel       = reg_sel_e'(addr_i[4:2]);
   assign w_wr        = req_i & we_i;
   assign w_bmask     = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
   assign w_bmask_src = w_bmask[NUM_SRC-1:0];
   assign w_wbits     = wdata_i[NUM_SRC-1:0] & w_bmask_src;
   assign w_set       = (w_wr && w_sel == REG_SET) ? w_wbits : '0;
   assign w_unused    = ^{addr_i, wdata_i};

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      assign w_clr[k] = (w_wr && w_sel == REG_PENDING && w_wbits[k])
                      || (irq_ack_i && irq_id_i == 5'(IRQ_FAST_BASE + k));
      irq_ctrl_src u_src (
         .clk       (clk),
         .rst       (rst),
         .i_src     (src_i[k]),
         .i_mode    (r_mode[k]),
         .i_set     (w_set[k]),
         .i_clr     (w_clr[k]),
         .o_pending (w_pending[k])
      );
   end

   // descending scan so the lowest pending+enabled source is the one left standing
   always_comb begin
      w_top = '0;
      for (int j = NUM_SRC - 1; j >= 0; j--) begin
         if (w_pending[j] && r_enable[j]) begin
            w_top                = '0;
            w_top[TOP_VALID_BIT] = 1'b1;
            w_top[4:0]           = 5'(IRQ_FAST_BASE + j);
         end
      end
   end

   assign w_rdata = w_sel == REG_ENABLE  ? 32'(r_enable)  :
                    w_sel == REG_MODE    ? 32'(r_mode)    :
                    w_sel == REG_PENDING ? 32'(w_pending) :
                    w_sel == REG_TOP     ? w_top          : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_enable <= '0;
         r_mode   <= '0;
         r_irq    <= '0;
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else begin
         if (w_wr && w_sel == REG_ENABLE) r_enable <= (r_enable & ~w_bmask_src) | w_wbits;
         if (w_wr && w_sel == REG_MODE) r_mode <= (r_mode & ~w_bmask_src) | w_wbits;
         r_irq    <= w_pending & r_enable;
         r_rvalid <= req_i;
         r_rdata  <= (req_i && !we_i) ? w_rdata : '0;
      end
   end

   always_comb begin
      irq_o                           = '0;
      irq_o[IRQ_FAST_BASE +: NUM_SRC] = r_irq;
   end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus random traffic, checked against a behavioural register model
module tb_irq_ctrl;
   localparam int N = 8;
   localparam logic [31:0] NMASK = 32'h0000_00FF;

   logic clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0, ack = 1'b0;
   logic [N-1:0] src = '0;
   logic [3:0] be = '0;
   logic [4:0] addr = '0, id = '0;
   logic [31:0] wdata = '0;
   logic gnt, rvalid;
   logic [31:0] rdata, irq;
   int errs = 0, checks = 0;

   logic [31:0] m_en = '0, m_md = '0, m_pd = '0, m_prev = '0, m_irq = '0, m_rd = '0;
   logic m_rv = 1'b0;

   always #5 clk = ~clk;

   irq_ctrl #(.NUM_SRC(N), .ADDR_W(5)) dut (
      .clk(clk), .rst(rst), .src_i(src), .req_i(req), .we_i(we), .be_i(be),
      .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid),
      .rdata_o(rdata), .irq_o(irq), .irq_ack_i(ack), .irq_id_i(id)
   );

   function automatic logic [31:0] bmask(input logic [3:0] b);
      return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
   endfunction

   function automatic logic [31:0] m_read(input logic [2:0] s);
      logic [31:0] r = '0;
      if (s == 3'd0) r = m_en;
      else if (s == 3'd1) r = m_md;
      else if (s == 3'd2) r = m_pd;
      else if (s == 3'd4)
         for (int i = N - 1; i >= 0; i--) if (m_pd[i] && m_en[i]) r = 32'h8000_0000 | 32'(16 + i);
      return r;
   endfunction

   function automatic logic [31:0] m_next_pd();
      logic [31:0] wd = wdata & bmask(be) & NMASK;
      logic [31:0] r = '0;
      for (int i = 0; i < N; i++) begin
         logic sw, clr;
         sw  = req && we && addr[4:2] == 3'd3 && wd[i];
         clr = (req && we && addr[4:2] == 3'd2 && wd[i]) || (ack && int'(id) == 16 + i);
         r[i] = m_md[i] ? (sw || (src[i] && !m_prev[i]) || (m_pd[i] && !clr)) : (src[i] || sw);
      end
      return r;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_en <= '0; m_md <= '0; m_pd <= '0; m_irq <= '0; m_rv <= 1'b0; m_rd <= '0;
      end else begin
         m_rv  <= req;
         m_rd  <= (req && !we) ? m_read(addr[4:2]) : '0;
         m_irq <= (m_pd & m_en) << 16;
         m_pd  <= m_next_pd();
         if (req && we && addr[4:2] == 3'd0) m_en <= (m_en & ~bmask(be)) | (wdata & bmask(be) & NMASK);
         if (req && we && addr[4:2] == 3'd1) m_md <= (m_md & ~bmask(be)) | (wdata & bmask(be) & NMASK);
      end
      m_prev <= 32'(src);
   end

   task automatic bus(input logic w, input logic [2:0] s, input logic [31:0] d, input logic [3:0] b = 4'hF);
      req = 1'b1; we = w; addr = {s, 2'b00}; wdata = d; be = b;
      @(negedge clk);
      req = 1'b0; we = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; src = 8'h01;
      repeat (2) @(negedge clk);
      checks++;
      if ({irq, rvalid, rdata} !== 65'b0) $display("FAIL reset: irq=%h rvalid=%b rdata=%h, expected all 0", irq, rvalid, rdata);
      if ({irq, rvalid, rdata} !== 65'b0) errs++;
      rst = 1'b0;
      bus(1, 3'd1, 32'h1); bus(1, 3'd2, 32'h1); bus(1, 3'd0, 32'h1);
      repeat (4) begin
         @(negedge clk);
         checks++;
         if (irq !== 32'h0 || irq !== m_irq) begin
            errs++; $display("FAIL no_edge_after_reset: irq=%h expected 0 (model %h)", irq, m_irq);
         end
      end
      src = '0;
   endtask

   task automatic test_edge();
      bus(1, 3'd1, 32'h4); bus(1, 3'd0, 32'h4);
      src[2] = 1'b1;
      @(negedge clk);
      checks++;
      if (irq[18] !== 1'b0) begin errs++; $display("FAIL edge_t1: irq[18]=%b expected 0", irq[18]); end
      @(negedge clk);
      checks++;
      if (irq !== 32'h0004_0000 || irq !== m_irq) begin errs++; $display("FAIL edge_t2: irq=%h expected 00040000", irq); end
      ack = 1'b1; id = 5'd18;
      @(negedge clk);
      ack = 1'b0;
      checks++;
      if (irq[18] !== 1'b1) begin errs++; $display("FAIL ack_t1: irq[18]=%b expected 1", irq[18]); end
      repeat (4) begin
         @(negedge clk);
         checks++;
         if (irq[18] !== 1'b0 || irq !== m_irq) begin errs++; $display("FAIL ack_cleared: irq=%h expected bit18=0 (model %h)", irq, m_irq); end
      end
      src[2] = 1'b0;
   endtask

   task automatic test_level();
      bus(1, 3'd1, 32'h0); bus(1, 3'd0, 32'h2);
      src[1] = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (irq !== 32'h0002_0000) begin errs++; $display("FAIL level_raise: irq=%h expected 00020000", irq); end
      bus(1, 3'd2, 32'h2);
      repeat (2) @(negedge clk);
      checks++;
      if (irq[17] !== 1'b1 || irq !== m_irq) begin errs++; $display("FAIL level_w1c: irq=%h expected bit17=1", irq); end
      src[1] = 1'b0;
      @(negedge clk);
      checks++;
      if (irq[17] !== 1'b1) begin errs++; $display("FAIL level_fall_t1: irq[17]=%b expected 1", irq[17]); end
      @(negedge clk);
      checks++;
      if (irq !== 32'h0) begin errs++; $display("FAIL level_fall_t2: irq=%h expected 0", irq); end
   endtask

   task automatic test_top();
      bus(1, 3'd1, 32'h28); bus(1, 3'd0, 32'h28); bus(1, 3'd3, 32'h28);
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b0 || rdata !== 32'h0) begin errs++; $display("FAIL idle_rvalid: rvalid=%b rdata=%h expected 0/0", rvalid, rdata); end
      bus(0, 3'd4, 32'h0);
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h8000_0013 || rdata !== m_rd) begin
         errs++; $display("FAIL top_3_5: rvalid=%b rdata=%h expected 1/80000013", rvalid, rdata);
      end
      bus(1, 3'd0, 32'h20); bus(0, 3'd4, 32'h0);
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h8000_0015) begin errs++; $display("FAIL top_5: rvalid=%b rdata=%h expected 1/80000015", rvalid, rdata); end
      bus(1, 3'd2, 32'h28);
      bus(0, 3'd4, 32'h0);
      checks++;
      if (rdata !== 32'h0) begin errs++; $display("FAIL top_empty: rdata=%h expected 0", rdata); end
   endtask

   task automatic test_collision();
      bus(1, 3'd1, 32'h10); bus(1, 3'd0, 32'h10);
      src[4] = 1'b1;
      bus(1, 3'd2, 32'h10);
      bus(0, 3'd2, 32'h0);
      checks++;
      if (rdata[4] !== 1'b1) begin errs++; $display("FAIL edge_vs_w1c: pending=%h expected bit4=1", rdata); end
      bus(1, 3'd2, 32'h10); bus(0, 3'd2, 32'h0);
      checks++;
      if (rdata[4] !== 1'b0) begin errs++; $display("FAIL w1c_clear: pending=%h expected bit4=0", rdata); end
      ack = 1'b1; id = 5'd20;
      bus(1, 3'd3, 32'h10);
      ack = 1'b0;
      bus(0, 3'd2, 32'h0);
      checks++;
      if (rdata[4] !== 1'b1 || rdata !== m_rd) begin errs++; $display("FAIL set_vs_ack: pending=%h expected bit4=1", rdata); end
      ack = 1'b1; id = 5'd5;
      @(negedge clk);
      ack = 1'b0;
      bus(0, 3'd2, 32'h0);
      checks++;
      if (rdata[4] !== 1'b1 || irq !== m_irq) begin errs++; $display("FAIL ack_out_of_range: pending=%h irq=%h expected bit4=1", rdata, irq); end
      src[4] = 1'b0;
      bus(1, 3'd2, 32'h10);
   endtask

   task automatic test_be_unmapped_rst();
      bus(1, 3'd0, 32'hFFFF_FFFF, 4'b0001);
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h0) begin errs++; $display("FAIL write_resp: rvalid=%b rdata=%h expected 1/0", rvalid, rdata); end
      bus(0, 3'd0, 32'h0);
      checks++;
      if (rdata !== 32'h0000_00FF) begin errs++; $display("FAIL be_enable: rdata=%h expected 000000ff", rdata); end
      bus(1, 3'd0, 32'h0, 4'b0000); bus(0, 3'd0, 32'h0);
      checks++;
      if (rdata !== 32'h0000_00FF) begin errs++; $display("FAIL be_none: rdata=%h expected 000000ff", rdata); end
      bus(1, 3'd7, 32'hFFFF_FFFF); bus(0, 3'd7, 32'h0);
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h0) begin errs++; $display("FAIL unmapped: rvalid=%b rdata=%h expected 1/0", rvalid, rdata); end
      bus(0, 3'd3, 32'h0);
      checks++;
      if (rdata !== 32'h0) begin errs++; $display("FAIL set_reads_zero: rdata=%h expected 0", rdata); end
      req = 1'b1; we = 1'b0; addr = 5'h00; rst = 1'b1;
      @(negedge clk);
      req = 1'b0; rst = 1'b0;
      checks++;
      if (rvalid !== 1'b0 || rdata !== 32'h0) begin errs++; $display("FAIL rst_drops_rvalid: rvalid=%b rdata=%h expected 0/0", rvalid, rdata); end
      bus(0, 3'd0, 32'h0);
      checks++;
      if (rdata !== 32'h0) begin errs++; $display("FAIL enable_after_rst: rdata=%h expected 0", rdata); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         src   = N'($urandom);
         req   = ($urandom_range(0, 2) != 0);
         we    = $urandom_range(0, 1) == 1;
         addr  = {3'($urandom_range(0, 7)), 2'b00};
         be    = 4'($urandom);
         wdata = $urandom;
         ack   = ($urandom_range(0, 3) == 0);
         id    = 5'($urandom_range(14, 27));
         #1;
         checks++;
         if (gnt !== req) begin errs++; $display("FAIL rand_gnt: gnt=%b expected %b", gnt, req); end
         @(negedge clk);
         checks++;
         if ({irq, rvalid, rdata} !== {m_irq, m_rv, m_rd}) begin
            errs++;
            $display("FAIL rand_cycle%0d: irq=%h rvalid=%b rdata=%h expected irq=%h rvalid=%b rdata=%h",
                     c, irq, rvalid, rdata, m_irq, m_rv, m_rd);
         end
      end
      req = 1'b0; ack = 1'b0;
   endtask

   task automatic test_back_to_back();
      bus(1, 3'd0, 32'h3C); bus(1, 3'd1, 32'h0);
      req = 1'b1; we = 1'b0;
      for (int s = 0; s < 3; s++) begin
         addr = {3'(s), 2'b00};
         @(negedge clk);
         checks++;
         if (rvalid !== 1'b1 || rdata !== m_rd) begin errs++; $display("FAIL b2b_%0d: rvalid=%b rdata=%h expected 1/%h", s, rvalid, rdata, m_rd); end
      end
      req = 1'b0;
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b0) begin errs++; $display("FAIL b2b_end: rvalid=%b expected 0", rvalid); end
   endtask

   initial begin
      test_reset();
      test_edge();
      test_level();
      test_top();
      test_collision();
      test_be_unmapped_rst();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
